// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP controller: 16-state TMS FSM, instruction register, DR select/enables, tdo mux.
// Optional IDCODE data register is built when TAP_IDCODE_EN is defined.
module tap_controller #(
    parameter int          IR_W       = 3,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tms,
    input  logic            tdi,
    output logic            tdo,
    output logic            tdo_en,
    output logic [3:0]      tap_state,
    output logic [IR_W-1:0] ir_out,
    output logic            capture_dr,
    output logic            shift_dr,
    output logic            update_dr,
    output logic            bp_shift,
    output logic            sel_bypass,
    output logic            sel_bsr,
    output logic            bs_mode,
    input  logic            bp_so,
    input  logic            bsr_so
);

    // state   | meaning
    // TLR     | test-logic-reset, IR forced to reset instruction
    // RTI     | run-test/idle
    // SEL_DR  | select DR scan
    // CAP_DR  | capture into selected DR
    // SH_DR   | shift selected DR, tdo driven
    // EX1_DR  | exit1 DR
    // PS_DR   | pause DR
    // EX2_DR  | exit2 DR
    // UPD_DR  | update selected DR
    // SEL_IR  | select IR scan
    // CAP_IR  | load capture pattern into IR shift stage
    // SH_IR   | shift IR stage, tdo driven
    // EX1_IR  | exit1 IR
    // PS_IR   | pause IR
    // EX2_IR  | exit2 IR
    // UPD_IR  | shift stage becomes active instruction
    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PS_DR  = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PS_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_e;

    localparam logic [IR_W-1:0] IR_EXTEST  = '0;
    localparam logic [IR_W-1:0] IR_SAMPLE  = IR_W'(1);
    localparam logic [IR_W-1:0] IR_INTEST  = IR_W'(2);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);
`ifdef TAP_IDCODE_EN
    localparam logic [IR_W-1:0] IR_IDCODE   = IR_W'(3);
    localparam logic [IR_W-1:0] RESET_INSTR = IR_IDCODE;
`else
    localparam logic [IR_W-1:0] RESET_INSTR = '1;
`endif

    if (IR_W < 3 || IDCODE_VAL[0] != 1'b1) begin : g_bad_params
        $error("tap_controller: IR_W must be >= 3 and IDCODE_VAL[0] must be 1");
    end

    tap_state_e      state_q, state_d;
    logic [IR_W-1:0] ir_shift_q, ir_shift_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            sel_idcode;
    logic            idcode_so;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= TLR;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = tms ? TLR    : RTI;
            RTI:    state_d = tms ? SEL_DR : RTI;
            SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms ? UPD_DR : PS_DR;
            PS_DR:  state_d = tms ? EX2_DR : PS_DR;
            EX2_DR: state_d = tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms ? SEL_DR : RTI;
            SEL_IR: state_d = tms ? TLR    : CAP_IR;
            CAP_IR: state_d = tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms ? UPD_IR : PS_IR;
            PS_IR:  state_d = tms ? EX2_IR : PS_IR;
            EX2_IR: state_d = tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Everything below is a pure function of registered state and sources.
    always_comb begin
        capture_dr = (state_q == CAP_DR);
        shift_dr   = (state_q == SH_DR);
        update_dr  = (state_q == UPD_DR);
        tdo_en     = (state_q == SH_DR) || (state_q == SH_IR);
        tdo        = 1'b0;
        if (state_q == SH_IR) begin
            tdo = ir_shift_q[0];
        end else if (state_q == SH_DR) begin
            if (sel_idcode)   tdo = idcode_so;
            else if (sel_bsr) tdo = bsr_so;
            else              tdo = bp_so;
        end
    end

    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_d       = ir_q;
        if (state_q == CAP_IR)     ir_shift_d = IR_CAPTURE;
        else if (state_q == SH_IR) ir_shift_d = {tdi, ir_shift_q[IR_W-1:1]};
        if (state_q == TLR)         ir_d = RESET_INSTR;
        else if (state_q == UPD_IR) ir_d = ir_shift_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_shift_q <= '0;
            ir_q       <= RESET_INSTR;
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_q       <= ir_d;
        end
    end

`ifdef TAP_IDCODE_EN
    logic [31:0] idcode_q, idcode_d;

    assign sel_idcode = (ir_q == IR_IDCODE);
    assign idcode_so  = idcode_q[0];

    always_comb begin
        idcode_d = idcode_q;
        if (sel_idcode && state_q == CAP_DR)     idcode_d = IDCODE_VAL;
        else if (sel_idcode && state_q == SH_DR) idcode_d = {tdi, idcode_q[31:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idcode_q <= '0;
        else        idcode_q <= idcode_d;
    end
`else
    assign sel_idcode = 1'b0;
    assign idcode_so  = 1'b0;
`endif

    assign sel_bsr    = (ir_q == IR_EXTEST) || (ir_q == IR_SAMPLE) || (ir_q == IR_INTEST);
    assign bs_mode    = (ir_q == IR_EXTEST) || (ir_q == IR_INTEST);
    assign sel_bypass = !sel_bsr && !sel_idcode;
    assign bp_shift   = shift_dr && sel_bypass;
    assign tap_state  = state_q;
    assign ir_out     = ir_q;

endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller: table-driven reference model, external bypass/BSR chains, random + directed TMS/TDI.
module tb_tap_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tms = 1'b1;
    logic       tdi = 1'b0;
    logic       tdo, tdo_en, capture_dr, shift_dr, update_dr, bp_shift;
    logic       sel_bypass, sel_bsr, bs_mode;
    logic [3:0] tap_state;
    logic [2:0] ir_out;
    logic       bp_env = 1'b0;
    logic [7:0] bsr_env = 8'h00;

    tap_controller #(.IR_W(3), .IDCODE_VAL(32'h1000_0001)) dut (
        .clk(clk), .rst_n(rst_n), .tms(tms), .tdi(tdi),
        .tdo(tdo), .tdo_en(tdo_en), .tap_state(tap_state), .ir_out(ir_out),
        .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
        .bp_shift(bp_shift), .sel_bypass(sel_bypass), .sel_bsr(sel_bsr),
        .bs_mode(bs_mode), .bp_so(bp_env), .bsr_so(bsr_env[0])
    );

    always #5 clk = ~clk;

    // External scan chains, driven by the DUT's enables.
    always @(posedge clk) begin
        if (capture_dr && sel_bypass) bp_env <= 1'b0;
        else if (bp_shift)            bp_env <= tdi;
        if (capture_dr && sel_bsr)     bsr_env <= 8'hA5;
        else if (shift_dr && sel_bsr)  bsr_env <= {tdi, bsr_env[7:1]};
    end

`ifdef TAP_IDCODE_EN
    localparam bit          ID_EN   = 1'b1;
    localparam logic [2:0]  RST_IR  = 3'b011;
`else
    localparam bit          ID_EN   = 1'b0;
    localparam logic [2:0]  RST_IR  = 3'b111;
`endif
    localparam logic [31:0] ID_VAL = 32'h1000_0001;

    typedef struct {
        logic [3:0] st;
        logic [2:0] ir;
        logic       tdo;
        logic       tdo_en;
        logic [6:0] ctrl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   drv_done = 1'b0;

    // Reference model state
    int         nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int         nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int         m_st  = 0;
    logic [2:0] m_ir  = RST_IR;
    logic [2:0] m_sh  = 3'b000;
    logic       m_bp  = 1'b0;
    logic [7:0] m_bsr = 8'h00;
    logic [31:0] m_id = 32'h0;

    function automatic exp_t predict();
        exp_t e;
        bit s_bsr, s_id, s_bp, bsm;
        s_bsr = (m_ir < 3);
        s_id  = ID_EN && (m_ir == 3);
        s_bp  = !s_bsr && !s_id;
        bsm   = (m_ir == 0) || (m_ir == 2);
        e.st     = 4'(m_st);
        e.ir     = m_ir;
        e.tdo_en = (m_st == 4) || (m_st == 11);
        if (m_st == 11)     e.tdo = m_sh[0];
        else if (m_st == 4) e.tdo = s_bp ? m_bp : (s_bsr ? m_bsr[0] : m_id[0]);
        else                e.tdo = 1'b0;
        e.ctrl = {m_st == 3, m_st == 4, m_st == 8, (m_st == 4) && s_bp, s_bp, s_bsr, bsm};
        return e;
    endfunction

    task automatic advance(input logic t, input logic d);
        bit s_bsr, s_id, s_bp;
        s_bsr = (m_ir < 3);
        s_id  = ID_EN && (m_ir == 3);
        s_bp  = !s_bsr && !s_id;
        if (m_st == 3 && s_bp)       m_bp = 1'b0;
        else if (m_st == 4 && s_bp)  m_bp = d;
        if (m_st == 3 && s_bsr)      m_bsr = 8'hA5;
        else if (m_st == 4 && s_bsr) m_bsr = (m_bsr >> 1) | (8'(d) << 7);
        if (m_st == 3 && s_id)       m_id = ID_VAL;
        else if (m_st == 4 && s_id)  m_id = (m_id >> 1) | (32'(d) << 31);
        if (m_st == 0)       m_ir = RST_IR;
        else if (m_st == 15) m_ir = m_sh;
        if (m_st == 10)      m_sh = 3'b001;
        else if (m_st == 11) m_sh = (m_sh >> 1) | (3'(d) << 2);
        m_st = t ? nxt1[m_st] : nxt0[m_st];
    endtask

    task automatic step(input logic t, input logic d, input logic r);
        @(negedge clk);
        rst_n = !r;
        tms   = t;
        tdi   = d;
        if (r) begin
            m_st = 0;
            m_ir = RST_IR;
            m_sh = 3'b000;
            m_id = 32'h0;
            exp_q.push_back(predict());
        end else begin
            exp_q.push_back(predict());
            advance(t, d);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b1);
    endtask

    // From RTI: load an instruction and return to RTI.
    task automatic load_ir(input logic [2:0] code);
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        for (int i = 0; i < 3; i++) step(i == 2, code[i], 0);
        step(1, 0, 0); step(0, 0, 0);
    endtask

    // From RTI: shift n DR bits and return to RTI.
    task automatic shift_dr_bits(input logic [31:0] bits, input int n);
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        for (int i = 0; i < n; i++) step(i == n - 1, bits[i], 0);
        step(1, 0, 0); step(0, 0, 0);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("tap_state", 8'(tap_state), 8'(e.st));
                check("ir_out", 8'(ir_out), 8'(e.ir));
                check("tdo", 8'(tdo), 8'(e.tdo));
                check("tdo_en", 8'(tdo_en), 8'(e.tdo_en));
                check("enables", 8'({capture_dr, shift_dr, update_dr, bp_shift, sel_bypass, sel_bsr, bs_mode}), 8'(e.ctrl));
            end
        end
    end

    int path_bits[16] = '{0, 0, 2, 2, 2, 10, 10, 42, 26, 6, 6, 6, 22, 22, 86, 54};
    int path_len[16]  = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
    logic [15:0] walk = 16'b1011_0011_1101_0010; // LSB first: 0,1,0,0,1,0,1,1,1,1,0,0,1,1,0,1

    initial begin : driver
        do_reset(); do_reset();
        for (int i = 0; i < 16; i++) step(walk[i], 1'b0, 1'b0);
        do_reset();
        // Reset from inside SH_DR
        step(0, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 1, 0); step(0, 1, 0);
        do_reset();
        // Five tms=1 cycles from every state
        for (int s = 0; s < 16; s++) begin
            do_reset();
            step(1, 0, 0);
            for (int i = 0; i < path_len[s]; i++) step(((path_bits[s] >> i) & 1) != 0, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) step(1, $urandom_range(0, 1), 0);
        end
        // IR load of EXTEST, then BYPASS and a bypass shift
        do_reset(); step(0, 0, 0);
        load_ir(3'b000);
        shift_dr_bits(32'h0000_005A, 8);
        load_ir(3'b111);
        shift_dr_bits(32'h0000_000D, 4);
        // Reset after two of three IR bits, then update without shifting
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(0, 1, 0); step(0, 0, 0);
        do_reset();
        step(0, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
        // IDCODE (or bypass without the option) straight out of reset
        do_reset();
        step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
        for (int i = 0; i < 32; i++) step(1'b0, $urandom_range(0, 1), 0);
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
        load_ir(3'b011);
        shift_dr_bits($urandom, 32);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 4) == 0, $urandom_range(0, 1), ($urandom % 250) == 0);
        end
        drv_done = 1'b1;
    end

    initial begin : finisher
        int waited;
        wait (drv_done);
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
